// File: rtl/tile_fetch_pipe.sv
// Tile-map fetch pipeline: turns scrolled pixel coordinates into a tile-map ROM
// address, realigns the returned tile index and in-tile pixel position with the
// delayed video syncs, and latches scroll updates only at frame boundaries.
module tile_fetch_pipe #(
  parameter int unsigned TILE_SHIFT = 3,
  parameter int unsigned MAP_COLS   = 80,
  parameter int unsigned MAP_ROWS   = 60,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned TILE_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            col,
  input  logic [9:0]            row,
  input  logic                  valid,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  scroll_valid,
  input  logic [11:0]           scroll_x,
  input  logic [11:0]           scroll_y,
  output logic                  scroll_ready,
  output logic                  scroll_err,
  output logic [ADDR_W-1:0]     addr,
  input  logic [TILE_W-1:0]     tile_in,
  output logic [TILE_W-1:0]     tile_out,
  output logic [TILE_SHIFT-1:0] pix_x,
  output logic [TILE_SHIFT-1:0] pix_y,
  output logic                  valid_out,
  output logic                  hsync_out,
  output logic                  vsync_out
);

  localparam int unsigned LAT   = ROM_LAT + 3;
  localparam logic [11:0] MAP_W = 12'(MAP_COLS << TILE_SHIFT);
  localparam logic [11:0] MAP_H = 12'(MAP_ROWS << TILE_SHIFT);

  // Scroll state
  logic [11:0] act_x_q, act_y_q, act_x_d, act_y_d;
  logic [11:0] pend_x_q, pend_y_q, pend_x_d, pend_y_d;
  logic        pend_q, pend_d;
  logic        err_q, err_d;

  logic        frame_start;
  logic        take_pend;
  logic        accept;
  logic        in_range;
  logic [11:0] use_x, use_y;

  // Pipeline state
  logic [11:0]           sx_q, sy_q;
  logic [11:0]           sx_wrap, sy_wrap;
  logic [ADDR_W-1:0]     addr_q;
  logic [TILE_SHIFT-1:0] px_q [ROM_LAT+1];
  logic [TILE_SHIFT-1:0] py_q [ROM_LAT+1];
  logic [LAT-1:0]        vld_sr, hs_sr, vs_sr;
  logic [TILE_W-1:0]     tile_q;
  logic [TILE_SHIFT-1:0] pix_x_q, pix_y_q;

  // Scroll handshake and frame-boundary transfer of the pending offset
  always_comb begin
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_d      = pend_q;
    err_d       = 1'b0;
    frame_start = (col == 10'd0) && (row == 10'd0);
    take_pend   = pend_q && frame_start;
    // Ready is simply "nothing pending", so a request can never collide with a
    // transfer; a request on a boundary cycle waits for the next boundary.
    accept      = scroll_valid && !pend_q;
    in_range    = (scroll_x < MAP_W) && (scroll_y < MAP_H);
    if (take_pend) begin
      act_x_d = pend_x_q;
      act_y_d = pend_y_q;
      pend_d  = 1'b0;
    end else if (accept) begin
      if (in_range) begin
        pend_x_d = scroll_x;
        pend_y_d = scroll_y;
        pend_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    // The boundary pixel itself already uses the new offset.
    use_x = take_pend ? pend_x_q : act_x_q;
    use_y = take_pend ? pend_y_q : act_y_q;
  end

  // Scroll state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_x_q  <= '0;
      act_y_q  <= '0;
      pend_x_q <= '0;
      pend_y_q <= '0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  // Single conditional subtract suffices: both operands are below the map size.
  always_comb begin
    sx_wrap = (sx_q >= MAP_W) ? sx_q - MAP_W : sx_q;
    sy_wrap = (sy_q >= MAP_H) ? sy_q - MAP_H : sy_q;
  end

  // Stage 1 add, stage 2 wrap/address, then in-tile position delay to the ROM return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q   <= '0;
      sy_q   <= '0;
      addr_q <= '0;
      for (int i = 0; i <= int'(ROM_LAT); i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
    end else begin
      sx_q    <= 12'(col) + use_x;
      sy_q    <= 12'(row) + use_y;
      addr_q  <= ADDR_W'(sy_wrap >> TILE_SHIFT) * ADDR_W'(MAP_COLS)
               + ADDR_W'(sx_wrap >> TILE_SHIFT);
      px_q[0] <= sx_wrap[TILE_SHIFT-1:0];
      py_q[0] <= sy_wrap[TILE_SHIFT-1:0];
      for (int i = 1; i <= int'(ROM_LAT); i++) begin
        px_q[i] <= px_q[i-1];
        py_q[i] <= py_q[i-1];
      end
    end
  end

  // Video flag/sync delay line: bit k holds the input delayed k+1 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
    end else begin
      vld_sr <= {vld_sr[LAT-2:0], valid};
      hs_sr  <= {hs_sr[LAT-2:0], hsync};
      vs_sr  <= {vs_sr[LAT-2:0], vsync};
    end
  end

  // Output stage: blank tile and position outside active video
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_q  <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end else if (vld_sr[LAT-2]) begin
      tile_q  <= tile_in;
      pix_x_q <= px_q[ROM_LAT];
      pix_y_q <= py_q[ROM_LAT];
    end else begin
      tile_q  <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
    end
  end

  assign scroll_ready = !pend_q;
  assign scroll_err   = err_q;
  assign addr         = addr_q;
  assign tile_out     = tile_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign valid_out    = vld_sr[LAT-1];
  assign hsync_out    = hs_sr[LAT-1];
  assign vsync_out    = vs_sr[LAT-1];

endmodule

// File: tb/tb_tile_fetch_pipe.sv
// Bench for tile_fetch_pipe: four instances (ROM_LAT 1..4) share one stimulus
// stream; a cycle-indexed reference model predicts every output, plus a table
// of directed probes with hand-computed addresses.
module tb_tile_fetch_pipe;

  localparam int MW = 640;
  localparam int MH = 480;
  localparam int HIST = 8192;

  logic        clk, rst_n;
  logic [9:0]  col, row;
  logic        valid, hsync, vsync;
  logic        scroll_valid;
  logic [11:0] scroll_x, scroll_y;

  logic [16:0] addr_w [4];
  logic [5:0]  tin [4];
  logic [5:0]  tout [4];
  logic [2:0]  pxw [4];
  logic [2:0]  pyw [4];
  logic        vo [4];
  logic        ho [4];
  logic        vso [4];
  logic        rdy [4];
  logic        errw [4];

  int nvec = 0;
  int nerr = 0;

  function automatic logic [5:0] rom(input logic [16:0] a);
    logic [16:0] t;
    t = a * 17'd13 + (a >> 5) + 17'd5;
    return t[5:0];
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_lat
    logic [5:0] rom_q [g+1];
    always_ff @(posedge clk) begin
      rom_q[0] <= rom(addr_w[g]);
      for (int i = 1; i <= g; i++) rom_q[i] <= rom_q[i-1];
    end
    assign tin[g] = rom_q[g];

    tile_fetch_pipe #(.ROM_LAT(g + 1)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .col          (col),
      .row          (row),
      .valid        (valid),
      .hsync        (hsync),
      .vsync        (vsync),
      .scroll_valid (scroll_valid),
      .scroll_x     (scroll_x),
      .scroll_y     (scroll_y),
      .scroll_ready (rdy[g]),
      .scroll_err   (errw[g]),
      .addr         (addr_w[g]),
      .tile_in      (tin[g]),
      .tile_out     (tout[g]),
      .pix_x        (pxw[g]),
      .pix_y        (pyw[g]),
      .valid_out    (vo[g]),
      .hsync_out    (ho[g]),
      .vsync_out    (vso[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: expected outputs per input cycle
  typedef struct {
    logic [16:0] addr;
    logic [5:0]  tile;
    logic [2:0]  px, py;
    logic        v, h, vs;
  } exp_t;

  exp_t hist [HIST];
  int   cyc = 0;
  int   base = 1;  // first cycle whose inputs the DUT captures after reset
  int   act_x, act_y, pend_x, pend_y;
  bit   pend_m, err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    act_x = 0; act_y = 0; pend_x = 0; pend_y = 0;
    pend_m = 0; err_m = 0;
    base = cyc + 1;
  endtask

  task automatic model_step();
    bit was_ready, bnd;
    int sx, sy, a;
    if (!rst_n) begin
      model_reset();
    end else begin
      was_ready = !pend_m;
      bnd = (col == 0) && (row == 0);
      if (bnd && pend_m) begin
        act_x = pend_x; act_y = pend_y; pend_m = 0;
      end
      sx = (int'(col) + act_x) % MW;
      sy = (int'(row) + act_y) % MH;
      a  = (sy / 8) * 80 + sx / 8;
      hist[cyc].addr = 17'(a);
      hist[cyc].tile = valid ? rom(17'(a)) : 6'd0;
      hist[cyc].px   = valid ? 3'(sx % 8) : 3'd0;
      hist[cyc].py   = valid ? 3'(sy % 8) : 3'd0;
      hist[cyc].v    = valid;
      hist[cyc].h    = hsync;
      hist[cyc].vs   = vsync;
      err_m = 0;
      if (scroll_valid && was_ready) begin
        if (scroll_x < MW && scroll_y < MH) begin
          pend_x = scroll_x; pend_y = scroll_y; pend_m = 1;
        end else begin
          err_m = 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    int s;
    exp_t e;
    logic [15:0] got, want;
    for (int g = 0; g < 4; g++) begin
      s = cyc - (g + 4);
      if (s < base) e = '{default: '0};
      else e = hist[s];
      got  = {tout[g], pxw[g], pyw[g], vo[g], ho[g], vso[g]};
      want = {e.tile, e.px, e.py, e.v, e.h, e.vs};
      chk($sformatf("outs_lat%0d", g + 1), 32'(got), 32'(want));
      s = cyc - 2;
      chk($sformatf("addr_lat%0d", g + 1), 32'(addr_w[g]), (s < base) ? 32'd0 : 32'(hist[s].addr));
      chk($sformatf("ready_lat%0d", g + 1), 32'(rdy[g]), 32'(!pend_m));
      chk($sformatf("err_lat%0d", g + 1), 32'(errw[g]), 32'(err_m));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    if (cyc >= HIST - 1) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, HIST - 1);
      $fatal(1);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    col = 10'd5; row = 10'd5; valid = 1'b0; scroll_valid = 1'b0;
  endtask

  // One pixel, then checks addr two cycles later and the ROM_LAT=1 outputs at +4
  task automatic probe(input string name, input int c, input int r, input bit sv,
                       input int rx, input int ry, input int ea, input int epx, input int epy);
    col = 10'(c); row = 10'(r); valid = 1'b1;
    scroll_valid = sv; scroll_x = 12'(rx); scroll_y = 12'(ry);
    cycle();
    idle();
    cycle();
    #3 chk({name, "_addr"}, 32'(addr_w[0]), 32'(ea));
    cycle();
    cycle();
    #3 chk({name, "_out"}, {20'd0, tout[0], pxw[0], pyw[0]},
           {20'd0, rom(17'(ea)), 3'(epx), 3'(epy)});
    chk({name, "_vout"}, 32'(vo[0]), 32'd1);
  endtask

  task automatic set_scroll(input int x, input int y);
    idle();
    scroll_valid = 1'b1; scroll_x = 12'(x); scroll_y = 12'(y);
    cycle();
    scroll_valid = 1'b0;
    #3 chk("ready_drop", 32'(rdy[0]), 32'd0);
    col = 10'd0; row = 10'd0;
    cycle();
    idle();
    #3 chk("ready_rise", 32'(rdy[0]), 32'd1);
  endtask

  typedef struct {
    int sx, sy, c, r, ea, epx, epy;
  } vec_t;

  vec_t tbl [10];
  int cur_x, cur_y;

  initial begin
    tbl[0] = '{0,   0,   17,  9,   82,   1, 1};
    tbl[1] = '{0,   0,   639, 479, 4799, 7, 7};
    tbl[2] = '{0,   0,   100, 200, 2012, 4, 0};
    tbl[3] = '{636, 0,   8,   0,   0,    4, 0};
    tbl[4] = '{636, 0,   0,   0,   79,   4, 0};
    tbl[5] = '{636, 0,   10,  3,   0,    6, 3};
    tbl[6] = '{16,  0,   0,   0,   2,    0, 0};
    tbl[7] = '{16,  8,   0,   0,   82,   0, 0};
    tbl[8] = '{639, 479, 639, 479, 4799, 6, 6};
    tbl[9] = '{0,   0,   5,   9,   80,   5, 1};

    rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0;
    scroll_x = '0; scroll_y = '0;
    idle();
    model_reset();
    #2;
    for (int g = 0; g < 4; g++) begin
      chk("rst_outs", {16'd0, tout[g], pxw[g], pyw[g], vo[g], ho[g], vso[g]}, 32'd0);
      chk("rst_ready", 32'(rdy[g]), 32'd1);
    end
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    cur_x = 0; cur_y = 0;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].sx != cur_x || tbl[i].sy != cur_y) begin
        set_scroll(tbl[i].sx, tbl[i].sy);
        cur_x = tbl[i].sx; cur_y = tbl[i].sy;
      end
      probe($sformatf("tbl%0d", i), tbl[i].c, tbl[i].r, 1'b0, 0, 0,
            tbl[i].ea, tbl[i].epx, tbl[i].epy);
    end

    // Out-of-range request: error pulse only, ready and scroll untouched
    idle();
    scroll_valid = 1'b1; scroll_x = 12'd0; scroll_y = 12'd480;
    cycle();
    idle();
    #3 chk("rej_err", 32'(errw[0]), 32'd1);
    chk("rej_ready", 32'(rdy[0]), 32'd1);
    cycle();
    #3 chk("rej_err_clr", 32'(errw[0]), 32'd0);
    probe("rej_keep", 17, 9, 1'b0, 0, 0, 82, 1, 1);

    // Request on the boundary cycle: old offset now, new one next frame
    probe("sim_bnd", 0, 0, 1'b1, 16, 0, 0, 0, 0);
    probe("sim_mid", 17, 9, 1'b0, 0, 0, 82, 1, 1);
    probe("sim_next", 0, 0, 1'b0, 0, 0, 2, 0, 0);

    // Randomized traffic with a mid-line reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        col = 10'd0; row = 10'd0;
      end else begin
        col = 10'($urandom_range(0, MW - 1));
        row = 10'($urandom_range(0, MH - 1));
      end
      valid = 1'($urandom_range(0, 3) != 0);
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      scroll_valid = ($urandom_range(0, 9) == 0);
      scroll_x = 12'($urandom_range(0, 700));
      scroll_y = 12'($urandom_range(0, 520));
      if (i == 1000) begin
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        for (int g = 0; g < 4; g++) begin
          chk("midrst_outs", {16'd0, tout[g], pxw[g], pyw[g], vo[g], ho[g], vso[g]}, 32'd0);
          chk("midrst_addr", 32'(addr_w[g]), 32'd0);
          chk("midrst_ready", 32'(rdy[g]), 32'd1);
        end
        cycle();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tile_fetch_pipe.md
TILE_FETCH_PIPE -- requirements
Module: tile_fetch_pipe

Interface
REQ-001 The block SHALL have parameter TILE_SHIFT, default 3, meaning log2 of the tile edge in pixels (8x8 tiles).
REQ-002 The block SHALL have parameter MAP_COLS, default 80, meaning the number of tiles per tile-map row.
REQ-003 The block SHALL have parameter MAP_ROWS, default 60, meaning the number of tile-map rows.
REQ-004 The block SHALL have parameter ROM_LAT, default 1 (legal range 1..4), meaning the clock cycles from addr to valid tile_in.
REQ-005 The block SHALL have parameter ADDR_W, default 17, meaning the tile-map address width.
REQ-006 The block SHALL have parameter TILE_W, default 6, meaning the tile index width.
REQ-007 The block SHALL have input clk, width 1: the pixel clock, the single clock of the block.
REQ-008 The block SHALL have input rst_n, width 1: asynchronous, active-low reset.
REQ-009 The block SHALL have inputs col and row, width 10 each: pixel coordinates from the vga timing block.
REQ-010 The block SHALL have inputs valid, hsync and vsync, width 1 each: active-video flag and syncs from the vga timing block.
REQ-011 The block SHALL have input scroll_valid, width 1: scroll update request.
REQ-012 The block SHALL have inputs scroll_x and scroll_y, width 12 each: requested pixel scroll offsets.
REQ-013 The block SHALL have output scroll_ready, width 1: high when the block accepts a scroll request.
REQ-014 The block SHALL have output scroll_err, width 1: one-cycle pulse flagging a rejected request.
REQ-015 The block SHALL have output addr, width ADDR_W: tile-map ROM address.
REQ-016 The block SHALL have input tile_in, width TILE_W: tile-map ROM data.
REQ-017 The block SHALL have output tile_out, width TILE_W: tile index aligned to the delayed pixel.
REQ-018 The block SHALL have outputs pix_x and pix_y, width TILE_SHIFT each: pixel position inside the tile.
REQ-019 The block SHALL have outputs valid_out, hsync_out and vsync_out, width 1 each: delayed copies of valid, hsync and vsync.

Function
REQ-020 The block SHALL define MAP_W = MAP_COLS<<TILE_SHIFT and MAP_H = MAP_ROWS<<TILE_SHIFT; inputs satisfy col<MAP_W and row<MAP_H whenever valid=1.
REQ-021 Stage 1 SHALL register sx = col+scroll_x_act and sy = row+scroll_y_act at 12-bit width with no overflow.
REQ-022 Stage 2 SHALL wrap with a single conditional subtract (sx>=MAP_W -> sx-MAP_W; likewise sy against MAP_H).
REQ-023 Stage 2 SHALL register addr = (sy>>TILE_SHIFT)*MAP_COLS + (sx>>TILE_SHIFT), with MAP_COLS*MAP_ROWS <= 2^ADDR_W.
REQ-024 The block SHALL define total latency LAT = ROM_LAT+3: inputs at cycle N appear on all outputs at cycle N+LAT.
REQ-025 addr SHALL be valid at cycle N+2 and tile_in sampled at N+2+ROM_LAT.
REQ-026 pix_x/pix_y SHALL equal the low TILE_SHIFT bits of the wrapped sx/sy, delayed to the same cycle as tile_out.
REQ-027 hsync, vsync and valid SHALL pass through a LAT-stage shift register with no logic change.
REQ-028 When valid_out=0, tile_out, pix_x and pix_y SHALL be 0, while addr continues to be computed.
REQ-029 Scroll handshake: a request SHALL be accepted on a cycle with scroll_valid=1 and scroll_ready=1.
REQ-030 An accepted request with scroll_x<MAP_W and scroll_y<MAP_H SHALL be stored as pending and scroll_ready SHALL drop the next cycle.
REQ-031 An accepted request with scroll_x>=MAP_W or scroll_y>=MAP_H SHALL be discarded, pulse scroll_err one cycle later and keep scroll_ready high.
REQ-032 Frame boundary: the pending value SHALL move to scroll_x_act/scroll_y_act on a cycle with col==0 and row==0 at the inputs, before that pixel's stage-1 add; scroll_ready SHALL rise the following cycle.
REQ-033 A request accepted in the same cycle as a frame boundary SHALL apply at the next frame boundary, not the current one.
REQ-034 With no pending value, a frame boundary SHALL leave the active scroll unchanged.
REQ-035 Active scroll SHALL never change mid-frame.

Reset
REQ-036 On rst_n=0 the block SHALL asynchronously clear all pipeline stages, addr, tile_out, pix_x, pix_y, valid_out, hsync_out, vsync_out, active and pending scroll and scroll_err to 0, and set scroll_ready=1.
REQ-037 Reset mid-frame SHALL discard any pending scroll; after release the outputs SHALL stay 0 for LAT cycles, then follow the inputs.

Verification
REQ-038 Default params, ROM_LAT=1, zero scroll, input col=17,row=9,valid=1 at N -> addr=82 at N+2, tile_out=ROM[82], pix_x=1, pix_y=1, valid_out=1 at N+4.
REQ-039 Wrap: scroll_x=636 applied, col=8,row=0 -> sx=644 wraps to 4, addr=0, pix_x=4; col=0 -> addr=79, pix_x=4.
REQ-040 Handshake: request scroll_x=16 mid-frame -> scroll_ready=0 next cycle, addresses unchanged until the col=0,row=0 boundary, next frame col=0 -> addr=2, scroll_ready=1 one cycle after the boundary.
REQ-041 Reject: scroll_y=480 (MAP_H=480) -> scroll_err pulses one cycle, scroll_ready stays 1, active scroll unchanged.
REQ-042 Simultaneous: request accepted on the boundary cycle -> the current frame uses the old offset, the next frame uses the new one.
REQ-043 Sweep ROM_LAT=1..4 with hsync/vsync toggling -> outputs equal inputs delayed exactly ROM_LAT+3 cycles; assert rst_n=0 mid-line -> all outputs 0 immediately, scroll_ready=1.
